// File: rtl/nor_responder.sv
// NOR flash responder: registered pin sampling, unlock/program command FSM,
// small AND-only backing store and busy/status-polling behaviour.
module nor_responder #(
  parameter int ADDRBITS    = 26,
  parameter int DATABITS    = 16,
  parameter int MEMBITS     = 4,
  parameter int PROG_CYCLES = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [ADDRBITS-1:0] nor_addr_i,
  input  logic [DATABITS-1:0] nor_data_i,
  input  logic                nor_ce_i,
  input  logic                nor_we_i,
  input  logic                nor_oe_i,
  output logic [DATABITS-1:0] nor_data_o,
  output logic                nor_data_oe,
  output logic                nor_ry_o,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_UNLOCK1  = 3'd1,
    ST_UNLOCK2  = 3'd2,
    ST_PROG_ARM = 3'd3,
    ST_BUSY     = 3'd4
  } state_t;

  localparam int           DEPTH     = 2 ** MEMBITS;
  localparam logic [7:0]   PROG_LOAD = 8'(PROG_CYCLES);

  // Two-stage pin sampling: s1 is the synchronised pin view, s2 the previous s1.
  logic                s1_ce, s1_we, s1_oe;
  logic                s2_ce, s2_we, s2_oe;
  logic [ADDRBITS-1:0] s1_addr, s2_addr;
  logic [DATABITS-1:0] s1_data, s2_data;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [DATABITS-1:0] pdata_q, pdata_d;
  logic                toggle_q, toggle_d;
  logic                mem_we;
  logic [DATABITS-1:0] mem_q [DEPTH];

  logic                strobe, rd_act, rd_rise, is_f0;
  logic [MEMBITS-1:0]  wr_idx, rd_idx;
  logic [DATABITS-1:0] status, rd_data;
  logic                unused_bits;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_ce   <= 1'b1;
      s1_we   <= 1'b1;
      s1_oe   <= 1'b1;
      s2_ce   <= 1'b1;
      s2_we   <= 1'b1;
      s2_oe   <= 1'b1;
      s1_addr <= '0;
      s2_addr <= '0;
      s1_data <= '0;
      s2_data <= '0;
    end else begin
      s1_ce   <= nor_ce_i;
      s1_we   <= nor_we_i;
      s1_oe   <= nor_oe_i;
      s2_ce   <= s1_ce;
      s2_we   <= s1_we;
      s2_oe   <= s1_oe;
      s1_addr <= nor_addr_i;
      s2_addr <= s1_addr;
      s1_data <= nor_data_i;
      s2_data <= s1_data;
    end
  end

  // Initiator protocol: a write is taken on the we# rising edge while ce# is
  // low (address/data from the cycle before); there is no backpressure, the
  // initiator must poll ry or the status word before issuing further commands.
  assign strobe  = !s1_ce && !s2_we && s1_we;
  assign rd_act  = !s1_ce && !s1_oe && s1_we;
  assign rd_rise = rd_act && !nor_data_oe;
  assign is_f0   = (s2_data[7:0] == 8'hF0);
  assign wr_idx  = s2_addr[MEMBITS-1:0];
  assign rd_idx  = s1_addr[MEMBITS-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pdata_q  <= '0;
      toggle_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pdata_q  <= pdata_d;
      toggle_q <= toggle_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pdata_d  = pdata_q;
    toggle_d = toggle_q;
    mem_we   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (strobe && !is_f0 && s2_addr[11:0] == 12'h555 && s2_data[7:0] == 8'hAA)
          state_d = ST_UNLOCK1;
      end
      ST_UNLOCK1: begin
        if (strobe) begin
          if (!is_f0 && s2_addr[11:0] == 12'h2AA && s2_data[7:0] == 8'h55)
            state_d = ST_UNLOCK2;
          else
            state_d = ST_IDLE;
        end
      end
      ST_UNLOCK2: begin
        if (strobe) begin
          if (!is_f0 && s2_addr[11:0] == 12'h555 && s2_data[7:0] == 8'hA0)
            state_d = ST_PROG_ARM;
          else
            state_d = ST_IDLE;
        end
      end
      ST_PROG_ARM: begin
        if (strobe) begin
          if (is_f0) begin
            state_d = ST_IDLE;
          end else begin
            mem_we   = 1'b1;
            pdata_d  = s2_data;
            cnt_d    = PROG_LOAD;
            toggle_d = 1'b0;
            state_d  = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        // Strobes are deliberately ignored here, including the F0 reset command.
        cnt_d = cnt_q - 8'd1;
        if (rd_rise)
          toggle_d = !toggle_q;
        if (cnt_q <= 8'd1) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Programming can only clear bits, so the store resets to the erased value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '1;
    end else if (mem_we) begin
      mem_q[wr_idx] <= mem_q[wr_idx] & s2_data;
    end
  end

  always_comb begin
    status    = '0;
    status[7] = !pdata_q[7];
    status[6] = toggle_q ^ rd_rise;
  end

  // Reads use the pre-write memory contents and the current (pre-edge) state.
  assign rd_data = (state_q == ST_BUSY) ? status : mem_q[rd_idx];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      nor_data_o  <= '0;
      nor_data_oe <= 1'b0;
      nor_ry_o    <= 1'b1;
    end else begin
      nor_data_oe <= rd_act;
      nor_ry_o    <= (state_d != ST_BUSY);
      if (rd_act)
        nor_data_o <= rd_data;
    end
  end

  assign dbg_state   = state_q;
  assign unused_bits = ^{s2_addr, s2_ce, s2_oe, pdata_q};

endmodule

// File: tb/tb_nor_responder.sv
// Self-checking bench for nor_responder: directed command sequences followed by
// randomized reads/programs scored against a command-level memory model.
module tb_nor_responder;

  localparam int AW = 26;
  localparam int DW = 16;
  localparam int MB = 4;
  localparam int PC = 8;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ce, we, oe;
  logic [DW-1:0] data_o;
  logic          data_oe, ry;
  logic [2:0]    dbg_state;

  nor_responder #(
    .ADDRBITS(AW), .DATABITS(DW), .MEMBITS(MB), .PROG_CYCLES(PC)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .nor_addr_i (addr),
    .nor_data_i (wdata),
    .nor_ce_i   (ce),
    .nor_we_i   (we),
    .nor_oe_i   (oe),
    .nor_data_o (data_o),
    .nor_data_oe(data_oe),
    .nor_ry_o   (ry),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model: command progress, erased/ANDed memory, busy status.
  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] exp_mem [2**MB];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_pdata;
  int            cmd_step;
  bit            in_busy;
  bit            tog;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2**MB; i++) exp_mem[i] = '1;
    cmd_step  = 0;
    in_busy   = 0;
    tog       = 0;
    exp_pdata = '0;
  endtask

  // Returns 1 when this write is expected to start a program operation.
  function automatic bit model_strobe(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit prog;
    prog = 0;
    if (d[7:0] == 8'hF0) begin
      cmd_step = 0;
    end else begin
      case (cmd_step)
        0: cmd_step = (a[11:0] == 12'h555 && d[7:0] == 8'hAA) ? 1 : 0;
        1: cmd_step = (a[11:0] == 12'h2AA && d[7:0] == 8'h55) ? 2 : 0;
        2: cmd_step = (a[11:0] == 12'h555 && d[7:0] == 8'hA0) ? 3 : 0;
        default: begin
          exp_mem[a[MB-1:0]] = exp_mem[a[MB-1:0]] & d;
          exp_pdata = d;
          prog      = 1;
          cmd_step  = 0;
        end
      endcase
    end
    return prog;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ry && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("ry_timeout", ry, 1'b1);
    in_busy = 0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit wait_busy);
    bit prog;
    int n;
    prog = model_strobe(a, d);
    @(negedge clk); ce = 0; we = 0; addr = a; wdata = d;
    @(negedge clk);
    @(negedge clk); we = 1;
    @(negedge clk); ce = 1;
    @(negedge clk);
    check("ry_after_write", ry, !prog);
    if (prog) begin
      in_busy = 1;
      tog     = 0;
      if (wait_busy) begin
        n = 1;
        while (n <= 300) begin
          @(negedge clk);
          if (ry) break;
          n++;
        end
        check("busy_len", n, PC);
        in_busy = 0;
      end
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    logic [DW-1:0] e;
    if (in_busy) begin
      tog  = !tog;
      e    = '0;
      e[7] = !exp_pdata[7];
      e[6] = tog;
    end else begin
      e = exp_mem[a[MB-1:0]];
    end
    exp_q.push_back(e);
    @(negedge clk); ce = 0; oe = 0; addr = a;
    @(posedge clk); #1;
    check("rd_latency", data_oe, 1'b0);
    @(posedge clk); #1;
    check("rd_oe", data_oe, 1'b1);
    check("rd_data", data_o, exp_q.pop_front());
    @(negedge clk); ce = 1; oe = 1;
  endtask

  task automatic program_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit wait_busy);
    do_write(26'h555, 16'h00AA, 1);
    do_write(26'h2AA, 16'h0055, 1);
    do_write(26'h555, 16'h00A0, 1);
    do_write(a, d, wait_busy);
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    int            op, bad_step;

    // Reset
    rst_ni = 0; ce = 1; we = 1; oe = 1; addr = '0; wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_data_oe", data_oe, 1'b0);
    check("rst_data_o", data_o, 16'h0000);
    check("rst_ry", ry, 1'b1);
    rst_ni = 1;
    @(negedge clk);

    // Erased read, program, bit clearing, output hold
    do_read(26'h3);
    check("erased_ry", ry, 1'b1);
    program_word(26'h3, 16'h1234, 1);
    do_read(26'h3);
    program_word(26'h3, 16'h00FF, 1);
    do_read(26'h3);
    repeat (3) @(negedge clk);
    check("hold_oe", data_oe, 1'b0);
    check("hold_data", data_o, 16'h0034);

    // Status polling during busy
    program_word(26'h9, 16'h1234, 0);
    do_read(26'h9);
    do_read(26'h9);
    wait_ready();
    do_read(26'h9);

    // Aborted sequences
    do_write(26'h555, 16'h00AA, 1);
    do_write(26'h2AB, 16'h0055, 1);
    do_write(26'h555, 16'h00A0, 1);
    do_write(26'h5, 16'hAAAA, 1);
    do_read(26'h5);
    do_write(26'h555, 16'h00AA, 1);
    do_write(26'h2AA, 16'h0055, 1);
    do_write(26'h123, 16'h00F0, 1);
    do_write(26'h555, 16'h00A0, 1);
    do_write(26'h7, 16'h0000, 1);
    do_read(26'h7);

    // Reset during busy
    program_word(26'hA, 16'h1234, 0);
    repeat (2) @(negedge clk);
    rst_ni = 0;
    #1;
    check("rst_busy_ry", ry, 1'b1);
    model_reset();
    @(negedge clk);
    rst_ni = 1;
    do_read(26'hA);
    do_read(26'h3);

    // Randomized traffic with aliased addresses
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 4);
      ra = AW'({$urandom, $urandom});
      rd = DW'($urandom);
      case (op)
        0, 1: do_read(ra);
        2: program_word(ra, rd, 1);
        3: begin
          bad_step = $urandom_range(0, 2);
          do_write((bad_step == 0) ? AW'($urandom) : {AW'($urandom) , 12'h555}, 16'h00AA, 1);
          do_write((bad_step == 1) ? AW'($urandom) : {AW'($urandom) , 12'h2AA}, 16'h0055, 1);
          do_write((bad_step == 2) ? AW'($urandom) : {AW'($urandom) , 12'h555},
                   (bad_step == 2) ? DW'($urandom) : 16'h00A0, 1);
          do_write(ra, rd, 1);
        end
        default: do_write(ra, {rd[15:8], 8'hF0}, 1);
      endcase
    end
    for (int i = 0; i < 2**MB; i++) do_read(AW'(i));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
